// File: rtl/float_mul_stage.sv
// Three-stage IEEE-754 single-precision multiplier (unpack, multiply, normalize/round/pack).
// Flush-to-zero on subnormal inputs and outputs; round to nearest, ties to even.
module float_mul_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              running,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [31:0]       out0   // versat_latency = 3
);

   generate
      if (DATA_W != 32) begin : g_bad_width
         $error("float_mul_stage: only DATA_W = 32 is supported");
      end
   endgenerate

   logic [7:0]  exp_a, exp_b;
   logic [22:0] frac_a, frac_b;
   logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic        nan_d, inf_d, zero_d;
   logic [9:0]  exp_sum_d;

   logic               s1_sign;
   logic signed [9:0]  s1_exp;
   logic [23:0]        s1_mant_a, s1_mant_b;
   logic               s1_nan, s1_inf, s1_zero;

   logic               s2_sign;
   logic signed [9:0]  s2_exp;
   logic [47:0]        s2_prod;
   logic               s2_nan, s2_inf, s2_zero;

   logic [22:0]        n_mant;
   logic               n_guard, n_sticky, round_up;
   logic signed [9:0]  n_exp, r_exp;
   logic [23:0]        r_mant;
   logic [31:0]        result;

   always_comb begin
      exp_a  = in0[30:23];
      exp_b  = in1[30:23];
      frac_a = in0[22:0];
      frac_b = in1[22:0];
      zero_a = (exp_a == 8'h00);
      zero_b = (exp_b == 8'h00);
      inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
      inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
      nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
      nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
      // inf * 0 is invalid and folds into the NaN flag
      nan_d  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
      inf_d  = inf_a | inf_b;
      zero_d = zero_a | zero_b;
      // 10 bits holds -127..383 without wrapping
      exp_sum_d = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sign   <= 1'b0;
         s1_exp    <= '0;
         s1_mant_a <= '0;
         s1_mant_b <= '0;
         s2_sign   <= 1'b0;
         s2_exp    <= '0;
         s2_prod   <= '0;
         out0      <= '0;
      end else if (running) begin
         s1_sign   <= in0[31] ^ in1[31];
         s1_exp    <= exp_sum_d;
         s1_mant_a <= {1'b1, frac_a};
         s1_mant_b <= {1'b1, frac_b};
         s2_sign   <= s1_sign;
         s2_exp    <= s1_exp;
         s2_prod   <= 48'(s1_mant_a) * 48'(s1_mant_b);
         out0      <= result;
      end
   end

   // A run pulse wipes the special-case flags regardless of running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
      end else if (run) begin
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
      end else if (running) begin
         s1_nan  <= nan_d;
         s1_inf  <= inf_d;
         s1_zero <= zero_d;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
      end
   end

   always_comb begin
      n_mant   = s2_prod[45:23];
      n_guard  = s2_prod[22];
      n_sticky = |s2_prod[21:0];
      n_exp    = s2_exp;
      if (s2_prod[47]) begin
         n_mant   = s2_prod[46:24];
         n_guard  = s2_prod[23];
         n_sticky = |s2_prod[22:0];
         n_exp    = s2_exp + 10'sd1;
      end
      round_up = n_guard & (n_sticky | n_mant[0]);
      // a carry out leaves r_mant[22:0] already zero
      r_mant   = {1'b0, n_mant} + {23'd0, round_up};
      r_exp    = r_mant[23] ? (n_exp + 10'sd1) : n_exp;

      if (s2_nan)
         result = 32'h7FC0_0000;
      else if (s2_inf)
         result = {s2_sign, 8'hFF, 23'd0};
      else if (s2_zero)
         result = {s2_sign, 31'd0};
      else if (r_exp >= 10'sd255)
         result = {s2_sign, 8'hFF, 23'd0};
      else if (r_exp <= 10'sd0)
         result = {s2_sign, 31'd0};
      else
         result = {s2_sign, r_exp[7:0], r_mant[22:0]};
   end

endmodule

// File: tb/tb_float_mul_stage.sv
// Bench for float_mul_stage: directed vectors plus randomized streams checked
// against an integer-arithmetic float32 reference model.
module tb_float_mul_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        running = 1'b0;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;
   logic [31:0] out0;

   int checks = 0;
   int failures = 0;

   float_mul_stage #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .run(run), .running(running),
      .in0(in0), .in1(in1), .out0(out0)
   );

   always #5 clk = ~clk;

   // Exact product, then rounded to a 24-bit significand by remainder comparison.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, k, sh, e;
      logic s, za, zb, ia, ib, na, nb;
      logic [63:0] p, q, rem, half;
      s  = a[31] ^ b[31];
      ea = {24'd0, a[30:23]};
      eb = {24'd0, b[30:23]};
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 23'd0);
      ib = (eb == 255) && (b[22:0] == 23'd0);
      na = (ea == 255) && (a[22:0] != 23'd0);
      nb = (eb == 255) && (b[22:0] != 23'd0);
      if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
      if (ia || ib) return {s, 8'hFF, 23'd0};
      if (za || zb) return {s, 31'd0};
      p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      k = p[47] ? 47 : 46;
      sh = k - 23;
      q = p >> sh;
      rem = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      e = ea + eb - 127 + (k - 46);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      int sel;
      logic [7:0] e;
      logic [22:0] f;
      sel = $urandom_range(0, 15);
      f = 23'($urandom);
      if (sel == 0) e = 8'h00;
      else if (sel == 1) e = 8'hFF;
      else if (sel == 2) begin e = 8'hFF; f = 23'd0; end
      else if (sel <= 5) e = 8'($urandom_range(1, 254));
      else e = 8'($urandom_range(100, 154));
      return {1'($urandom), e, f};
   endfunction

   task automatic tick(input logic [31:0] a, input logic [31:0] b, input logic rn);
      in0 = a;
      in1 = b;
      running = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out0 !== 32'h0) begin failures++; $display("FAIL reset_out0: got %h want %h", out0, 32'h0); end
      rst = 1'b0;
      tick(32'h3F800000, 32'h3F800000, 1'b0);
      tick(32'h3F800000, 32'h3F800000, 1'b0);
      checks++;
      if (out0 !== 32'h0) begin failures++; $display("FAIL reset_idle_hold: got %h want %h", out0, 32'h0); end
   endtask

   task automatic test_basic();
      logic [31:0] va [0:2] = '{32'h3FC00000, 32'hC0000000, 32'h3F800000};
      logic [31:0] vb [0:2] = '{32'h40000000, 32'h40400000, 32'hBF800000};
      logic [31:0] ve [0:2] = '{32'h40400000, 32'hC0C00000, 32'hBF800000};
      for (int i = 0; i < 5; i++) begin
         tick(i < 3 ? va[i] : 32'h0, i < 3 ? vb[i] : 32'h0, 1'b1);
         if (i >= 2) begin
            checks++;
            if (out0 !== ve[i-2]) begin failures++; $display("FAIL basic[%0d]: got %h want %h", i-2, out0, ve[i-2]); end
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] va [0:2] = '{32'h3F800001, 32'h3F800003, 32'h3F800001};
      logic [31:0] vb [0:2] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000};
      logic [31:0] ve [0:2] = '{32'h3F800002, 32'h3FC00004, 32'h3FC00002};
      for (int i = 0; i < 5; i++) begin
         tick(i < 3 ? va[i] : 32'h0, i < 3 ? vb[i] : 32'h0, 1'b1);
         if (i >= 2) begin
            checks++;
            if (out0 !== ve[i-2]) begin failures++; $display("FAIL rounding[%0d]: got %h want %h", i-2, out0, ve[i-2]); end
         end
      end
   endtask

   task automatic test_range();
      logic [31:0] va [0:4] = '{32'h7F000000, 32'h00800000, 32'h80800000, 32'h00000001, 32'h3FFFFFFF};
      logic [31:0] vb [0:4] = '{32'h40000000, 32'h3F000000, 32'h3F000000, 32'h40000000, 32'h3FFFFFFF};
      logic [31:0] ve [0:4] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h407FFFFE};
      for (int i = 0; i < 7; i++) begin
         tick(i < 5 ? va[i] : 32'h0, i < 5 ? vb[i] : 32'h0, 1'b1);
         if (i >= 2) begin
            checks++;
            if (out0 !== ve[i-2]) begin failures++; $display("FAIL range[%0d]: got %h want %h", i-2, out0, ve[i-2]); end
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [0:4] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80000000, 32'h00000000};
      logic [31:0] vb [0:4] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'hFF800000};
      logic [31:0] ve [0:4] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000};
      for (int i = 0; i < 7; i++) begin
         tick(i < 5 ? va[i] : 32'h0, i < 5 ? vb[i] : 32'h0, 1'b1);
         if (i >= 2) begin
            checks++;
            if (out0 !== ve[i-2]) begin failures++; $display("FAIL specials[%0d]: got %h want %h", i-2, out0, ve[i-2]); end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] pa [0:3];
      logic [31:0] pb [0:3];
      logic [31:0] pe [0:3];
      for (int i = 0; i < 4; i++) begin
         pa[i] = rand_op();
         pb[i] = rand_op();
         pe[i] = ref_mul(pa[i], pb[i]);
      end
      tick(pa[0], pb[0], 1'b1);
      tick(pa[1], pb[1], 1'b1);
      tick(pa[2], pb[2], 1'b1);
      checks++;
      if (out0 !== pe[0]) begin failures++; $display("FAIL stall_pre: got %h want %h", out0, pe[0]); end
      for (int c = 0; c < 5; c++) begin
         tick($urandom, $urandom, 1'b0);
         checks++;
         if (out0 !== pe[0]) begin failures++; $display("FAIL stall_hold[%0d]: got %h want %h", c, out0, pe[0]); end
      end
      for (int i = 1; i < 4; i++) begin
         tick(i == 1 ? pa[3] : 32'h0, i == 1 ? pb[3] : 32'h0, 1'b1);
         checks++;
         if (out0 !== pe[i]) begin failures++; $display("FAIL stall_post[%0d]: got %h want %h", i, out0, pe[i]); end
      end
   endtask

   task automatic test_run_clear();
      // flags of the pairs in flight at the run edge are dropped: inf*0 becomes 1.0*1.0*2^1,
      // and the NaN operand takes the normal path with exponent 255 (overflow to +inf)
      tick(32'h40000000, 32'h40400000, 1'b1);
      tick(32'h7F800000, 32'h00000000, 1'b1);
      run = 1'b1;
      tick(32'h7FC00001, 32'h3F800000, 1'b1);
      run = 1'b0;
      checks++;
      if (out0 !== 32'h40C00000) begin failures++; $display("FAIL run_keeps_out0: got %h want %h", out0, 32'h40C00000); end
      tick(32'h0, 32'h0, 1'b1);
      checks++;
      if (out0 !== 32'h40000000) begin failures++; $display("FAIL run_clear_s2: got %h want %h", out0, 32'h40000000); end
      tick(32'h0, 32'h0, 1'b1);
      checks++;
      if (out0 !== 32'h7F800000) begin failures++; $display("FAIL run_clear_s1: got %h want %h", out0, 32'h7F800000); end
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic [31:0] a, b, held;
      logic rn;
      bit have = 0;
      held = '0;
      for (int i = 0; i < 400; i++) begin
         a = rand_op();
         b = rand_op();
         rn = ($urandom_range(0, 9) != 0);
         tick(a, b, rn);
         if (rn) begin
            q.push_back(ref_mul(a, b));
            if (q.size() == 3) begin
               held = q.pop_front();
               have = 1;
               checks++;
               if (out0 !== held) begin failures++; $display("FAIL random[%0d]: got %h want %h", i, out0, held); end
            end
         end else if (have) begin
            checks++;
            if (out0 !== held) begin failures++; $display("FAIL random_hold[%0d]: got %h want %h", i, out0, held); end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] pa [0:2];
      logic [31:0] pb [0:2];
      tick(32'h3FC00000, 32'h40000000, 1'b1);
      tick(32'h40400000, 32'h40400000, 1'b1);
      tick(32'h40800000, 32'h3F000000, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (out0 !== 32'h0) begin failures++; $display("FAIL async_reset_out0: got %h want %h", out0, 32'h0); end
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pa[i] = rand_op();
         pb[i] = rand_op();
      end
      tick(pa[0], pb[0], 1'b1);
      checks++;
      if (out0 !== 32'h0) begin failures++; $display("FAIL async_reset_flushed: got %h want %h", out0, 32'h0); end
      tick(pa[1], pb[1], 1'b1);
      tick(pa[2], pb[2], 1'b1);
      checks++;
      if (out0 !== ref_mul(pa[0], pb[0])) begin failures++; $display("FAIL post_reset[0]: got %h want %h", out0, ref_mul(pa[0], pb[0])); end
      tick(32'h0, 32'h0, 1'b1);
      checks++;
      if (out0 !== ref_mul(pa[1], pb[1])) begin failures++; $display("FAIL post_reset[1]: got %h want %h", out0, ref_mul(pa[1], pb[1])); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_range();
      test_specials();
      test_stall();
      test_run_clear();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
